// File: rtl/seq_div32.sv
// seq_div32 - sequential restoring divider, one quotient bit per clock.
//
// Accepts a dividend/divisor pair on a start pulse, iterates WIDTH restoring
// steps on operand magnitudes, then applies the result signs in a final fix-up
// cycle. Signed (two's complement) and unsigned modes.
//
// Ports:
//   CLK          rising-edge clock
//   reset        asynchronous, active-high reset
//   start        request; sampled only when not busy
//   sign_mode    1 = signed, 0 = unsigned; sampled with start
//   in_a         dividend; sampled with start
//   in_b         divisor; sampled with start
//   quotient     result quotient
//   remainder    result remainder (sign follows the dividend)
//   out_valid    result valid level, held until the next accepted start
//   busy         high while a division is in progress
//   div_by_zero  set together with out_valid when the divisor was zero
module seq_div32 #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             out_valid,
  output logic             busy,
  output logic             div_by_zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q;
  // Partial remainder: after every restoring step it is strictly below the
  // divisor, so its top (WIDTH+1-th) bit is always zero and only the trial
  // difference needs the extra bit.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;      // dividend magnitude, becomes the quotient
  logic [WIDTH-1:0] dsr_q;      // divisor magnitude
  logic [CW-1:0]    cnt_q;
  logic             quo_neg_q;
  logic             rem_neg_q;

  logic             a_neg_s;
  logic             b_neg_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH:0]   shift_s;
  logic [WIDTH:0]   trial_s;

  // Operand magnitudes at accept and the trial subtraction for one CALC step.
  always_comb begin
    a_neg_s = sign_mode & in_a[WIDTH-1];
    b_neg_s = sign_mode & in_b[WIDTH-1];
    a_mag_s = a_neg_s ? (~in_a + {{(WIDTH-1){1'b0}}, 1'b1}) : in_a;
    b_mag_s = b_neg_s ? (~in_b + {{(WIDTH-1){1'b0}}, 1'b1}) : in_b;
    shift_s = {rem_q, dvd_q[WIDTH-1]};
    trial_s = shift_s - {1'b0, dsr_q};
  end

  // Divider FSM: accept, iterate, sign fix-up, hold result.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      cnt_q       <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            quo_neg_q <= a_neg_s ^ b_neg_s;
            rem_neg_q <= a_neg_s;
            dvd_q     <= a_mag_s;
            dsr_q     <= b_mag_s;
            rem_q     <= '0;
            cnt_q     <= '0;
            if (in_b == '0) begin
              // Zero divisor: answer immediately, never go busy.
              quotient    <= '1;
              remainder   <= in_a;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              busy        <= 1'b0;
              state_q     <= S_DONE;
            end else begin
              div_by_zero <= 1'b0;
              out_valid   <= 1'b0;
              busy        <= 1'b1;
              state_q     <= S_CALC;
            end
          end else begin
            state_q <= state_q;
          end
        end
        S_CALC: begin
          // Non-negative trial keeps the difference and yields a 1 bit;
          // otherwise restore the shifted remainder and yield a 0 bit.
          if (!trial_s[WIDTH]) begin
            rem_q <= trial_s[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= shift_s[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_CALC;
          end
        end
        S_FIX: begin
          // Two's complement negation wraps, so -2^(W-1)/-1 gives 2^(W-1).
          quotient  <= quo_neg_q ? (~dvd_q + {{(WIDTH-1){1'b0}}, 1'b1}) : dvd_q;
          remainder <= rem_neg_q ? (~rem_q + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state_q   <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div32.sv
// Self-checking bench for seq_div32: directed and random divisions, a
// scoreboard queue filled by the driver and drained by an independent monitor.
module tb_seq_div32;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sign_mode;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        out_valid;
  logic        busy;
  logic        div_by_zero;

  seq_div32 #(.WIDTH(32)) dut (
    .CLK        (clk),
    .reset      (reset),
    .start      (start),
    .sign_mode  (sign_mode),
    .in_a       (in_a),
    .in_b       (in_b),
    .quotient   (quotient),
    .remainder  (remainder),
    .out_valid  (out_valid),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          due_edge;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to check result latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void ref_div(input logic sm, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitor: every rising out_valid must match the oldest expected result.
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && !prev_v) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got q=%h r=%h, expected none", quotient, remainder);
        end else begin
          e = sb_q.pop_front();
          chk("quotient", quotient, e.q);
          chk("remainder", remainder, e.r);
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
          chk("latency_edge", cyc, e.due_edge);
          if (!e.dz) chk("identity_q*b+r", quotient * e.b + remainder, e.a);
        end
      end
      prev_v = out_valid;
    end
  end

  // Issue one division from IDLE/DONE and follow it to completion.
  // poke=1 pulses a bogus start in the middle of CALC.
  task automatic run_div(input logic sm, input logic [31:0] a, input logic [31:0] b, input bit poke);
    exp_t e;
    @(negedge clk);
    sign_mode = sm;
    in_a      = a;
    in_b      = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e.a = a;
    e.b = b;
    e.dz = (b == 32'd0);
    ref_div(sm, a, b, e.q, e.r);
    e.due_edge = cyc + ((b == 32'd0) ? 0 : 33);
    sb_q.push_back(e);
    @(negedge clk);
    start     = 1'b0;
    in_a      = $urandom;
    in_b      = $urandom;
    sign_mode = 1'($urandom);
    if (b == 32'd0) begin
      chk("dbz_busy_low", {31'd0, busy}, 32'd0);
      chk("dbz_valid_now", {31'd0, out_valid}, 32'd1);
    end else begin
      // Negedges after E0..E32: busy high, result not yet valid.
      for (int i = 1; i <= 33; i++) begin
        chk("busy_during", {31'd0, busy}, 32'd1);
        chk("valid_low_during", {31'd0, out_valid}, 32'd0);
        if (poke && i == 10) begin
          start     = 1'b1;
          in_b      = 32'd0;
          sign_mode = 1'b1;
        end
        if (i == 11) start = 1'b0;
        @(negedge clk);
      end
      chk("busy_after", {31'd0, busy}, 32'd0);
      chk("valid_after", {31'd0, out_valid}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sm;
    reset     = 1'b1;
    start     = 1'b0;
    sign_mode = 1'b0;
    in_a      = 32'd0;
    in_b      = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;

    run_div(1'b0, 32'd90, 32'd30, 1'b1);
    run_div(1'b0, 32'd100, 32'd9, 1'b0);
    run_div(1'b1, -32'sd95, 32'd30, 1'b0);
    run_div(1'b1, 32'd95, -32'sd30, 1'b0);
    run_div(1'b1, -32'sd95, -32'sd30, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Reset 10 edges into CALC of 1000/7 aborts with no result.
    @(negedge clk);
    sign_mode = 1'b0;
    in_a      = 32'd1000;
    in_b      = 32'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_div(1'b0, 32'd1234, 32'd0, 1'b0);
    run_div(1'b0, 32'd1000, 32'd7, 1'b0);

    for (int n = 0; n < 40; n++) begin
      sm = 1'($urandom);
      a  = $urandom;
      b  = (n % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (n % 5 == 1) b = -b;
      if (b == 32'd0) b = 32'd3;
      run_div(sm, a, b, (n % 7 == 0));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
